// File: rtl/serial_word_receiver_if.sv
// Bundle of serial-side and parallel-side signals for serial_word_receiver.
// master = serial source / consumer side, slave = the receiver itself.
interface serial_word_receiver_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 2);

    logic             ser_in;
    logic             ser_valid;
    logic             sync;
    logic             dir;
    logic             out_ready;
    logic [WIDTH-1:0] A_par;
    logic             out_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;
    logic             parity_err;

    modport master (
        output ser_in, ser_valid, sync, dir, out_ready,
        input  A_par, out_valid, overrun, bit_cnt, parity_err
    );

    modport slave (
        input  ser_in, ser_valid, sync, dir, out_ready,
        output A_par, out_valid, overrun, bit_cnt, parity_err
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with a one-entry valid/ready output buffer.
// Define SERIAL_RX_PARITY_EN for frames carrying a trailing even-parity bit.
module serial_word_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Clear,
    serial_word_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] a_par_q, a_par_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             parity_err_q, parity_err_d;
    logic             word_err;
`endif

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             accept;
    logic             last_bit;
    logic             complete;
    logic             consume;

    // sync wins over a coincident strobe, so the strobe never counts as a bit
    assign accept   = (state_q == ST_RECV) && bus.ser_valid && !bus.sync;
    assign last_bit = (bit_cnt_q == CNT_W'(FRAME - 1));
    assign complete = accept && last_bit;
    assign consume  = out_valid_q && bus.out_ready;

    assign shifted = dir_q ? {shreg_q[WIDTH-2:0], bus.ser_in}
                           : {bus.ser_in, shreg_q[WIDTH-1:1]};

`ifdef SERIAL_RX_PARITY_EN
    // The final frame bit is parity, so the data word is already complete in shreg.
    assign word     = shreg_q;
    assign word_err = par_acc_q ^ bus.ser_in;
`else
    assign word     = shifted;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        dir_d       = dir_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        a_par_d     = a_par_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
        par_acc_d    = par_acc_q;
        parity_err_d = parity_err_q;
`endif

        if (bus.sync) begin
            state_d   = ST_RECV;
            dir_d     = bus.dir;
            shreg_d   = '0;
            bit_cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            par_acc_d = 1'b0;
`endif
        end else if (accept) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
`ifdef SERIAL_RX_PARITY_EN
            if (!last_bit) begin
                shreg_d = shifted;
            end
            par_acc_d = last_bit ? 1'b0 : (par_acc_q ^ bus.ser_in);
`else
            shreg_d = shifted;
`endif
        end

        // A buffer being drained on this edge can take the new word directly.
        if (complete && (!out_valid_q || bus.out_ready)) begin
            a_par_d     = word;
            out_valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_d = word_err;
`endif
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (Clear) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            a_par_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            a_par_q     <= a_par_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
            par_acc_q    <= par_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.A_par     = a_par_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.bit_cnt   = bit_cnt_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
